// File: rtl/mem_mapper.sv
// CPU memory map and SDRAM sequencer: per clk_800k cycle runs instruction fetch, data access, then optional VGA burst.
// Optional UART status read at 16'hF808 is enabled by defining MEM_MAP_UART_STATUS_EN.
module mem_mapper #(
   parameter logic [15:0] VGA_MMIO_ADDR = 16'hF80C,
   parameter logic [15:0] MMIO_BASE     = 16'hF800,
   parameter logic [5:0]  VGA_BANK      = 6'h1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_800k,
   input  logic [15:0]       pc,
   input  logic [15:0]       data_addr,
   input  logic [15:0]       data_in,
   input  logic              write_en,
   input  logic              vga_en,
   input  logic [4:0]        vga_x_group,
   input  logic [8:0]        vga_y_val,
   input  logic              uart_tx_ready,
   output logic [15:0]       instr,
   output logic [15:0]       read_data,
   output logic [31:0][11:0] vga_bgr_buf,
   output logic [24:0]       dram_addr,
   output logic [15:0]       dram_data_in,
   output logic              dram_write_en,
   output logic              dram_burst_en,
   output logic              dram_refresh_data,
   input  logic [15:0]       dram_read_data,
   input  logic [31:0][15:0] dram_burst_buf,
   input  logic              dram_data_ready,
   input  logic              cpu_ready
);

   typedef enum logic [1:0] {IDLE, INSTR, DATA, VGA} state_t;

   state_t state_q, state_d;
   logic   issued_q, issued_d, pending_q, pending_d, clk_800k_q;
   logic [15:0] s_pc_q, s_pc_d, s_addr_q, s_addr_d, s_din_q, s_din_d;
   logic        s_we_q, s_we_d, s_ven_q, s_ven_d;
   logic [4:0]  s_xg_q, s_xg_d;
   logic [8:0]  s_yv_q, s_yv_d;
   logic [1:0]  phase_q, phase_d;
   logic [9:0]  px_q, px_d;
   logic [8:0]  py_q, py_d;
   logic [15:0] instr_q, instr_d, rdata_q, rdata_d;
   logic [31:0][11:0] vga_q, vga_d;
   logic [24:0] daddr_q, daddr_d, req_addr;
   logic [15:0] ddat_q, ddat_d, req_dat, mmio_rdata;
   logic        dwe_q, dwe_d, dburst_q, dburst_d, refresh_q, refresh_d;
   logic        req_we, req_burst, rise, pix_commit, need_data;
   logic        unused_bits;

   assign rise       = clk_800k & ~clk_800k_q;
   assign pix_commit = s_we_q && (s_addr_q == VGA_MMIO_ADDR) && (phase_q == 2'd2);
   assign need_data  = (s_addr_q < MMIO_BASE) || pix_commit;

`ifdef MEM_MAP_UART_STATUS_EN
   assign mmio_rdata = (s_addr_q == 16'hF808) ? {15'b0, uart_tx_ready} : 16'h0;
`else
   assign mmio_rdata = 16'h0;
`endif

   always_comb begin
      unused_bits = 1'b0;
      for (int i = 0; i < 32; i++) unused_bits = unused_bits ^ (^dram_burst_buf[i][15:12]);
`ifndef MEM_MAP_UART_STATUS_EN
      unused_bits = unused_bits ^ uart_tx_ready;
`endif
   end

   always_comb begin
      req_addr  = {9'b0, s_pc_q};
      req_dat   = 16'h0;
      req_we    = 1'b0;
      req_burst = 1'b0;
      case (state_q)
         DATA: begin
            if (pix_commit) begin
               req_addr = {VGA_BANK, py_q, px_q};
               req_dat  = {4'b0, s_din_q[11:0]};
               req_we   = 1'b1;
            end else begin
               req_addr = {9'b0, s_addr_q};
               req_dat  = s_din_q;
               req_we   = s_we_q;
            end
         end
         VGA: begin
            req_addr  = {VGA_BANK, s_yv_q, s_xg_q, 5'b0};
            req_burst = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;   issued_d = issued_q;  pending_d = pending_q;
      s_pc_d    = s_pc_q;    s_addr_d = s_addr_q;  s_din_d   = s_din_q;
      s_we_d    = s_we_q;    s_ven_d  = s_ven_q;   s_xg_d    = s_xg_q;
      s_yv_d    = s_yv_q;    phase_d  = phase_q;   px_d      = px_q;
      py_d      = py_q;      instr_d  = instr_q;   rdata_d   = rdata_q;
      vga_d     = vga_q;     daddr_d  = daddr_q;   ddat_d    = ddat_q;
      dwe_d     = dwe_q;     dburst_d = dburst_q;  refresh_d = 1'b0;
      if (state_q == IDLE) begin
         if (rise || pending_q) begin
            state_d   = INSTR;
            pending_d = 1'b0;
            s_pc_d    = pc;        s_addr_d = data_addr;  s_din_d = data_in;
            s_we_d    = write_en;  s_ven_d  = vga_en;
            s_xg_d    = vga_x_group;  s_yv_d = vga_y_val;
         end
      end else begin
         if (rise) pending_d = 1'b1;
         if (!issued_q) begin
            if (cpu_ready) begin
               issued_d  = 1'b1;
               refresh_d = 1'b1;
               daddr_d   = req_addr;  ddat_d = req_dat;
               dwe_d     = req_we;    dburst_d = req_burst;
            end
         end else if (dram_data_ready) begin
            issued_d = 1'b0;
            dwe_d    = 1'b0;
            dburst_d = 1'b0;
            case (state_q)
               INSTR: begin
                  instr_d = dram_read_data;
                  // MMIO side effects that need no DRAM cycle are resolved here.
                  if (need_data) state_d = DATA;
                  else begin
                     state_d = s_ven_q ? VGA : IDLE;
                     if (!s_we_q) rdata_d = mmio_rdata;
                     else if (s_addr_q == VGA_MMIO_ADDR) begin
                        if (phase_q == 2'd0) begin
                           px_d = s_din_q[9:0];  phase_d = 2'd1;
                        end else begin
                           py_d = s_din_q[8:0];  phase_d = 2'd2;
                        end
                     end
                  end
               end
               DATA: begin
                  if (pix_commit) phase_d = 2'd0;
                  else if (!s_we_q) rdata_d = dram_read_data;
                  state_d = s_ven_q ? VGA : IDLE;
               end
               VGA: begin
                  for (int i = 0; i < 32; i++) vga_d[i] = dram_burst_buf[i][11:0];
                  state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;   issued_q <= 1'b0;  pending_q <= 1'b0;  clk_800k_q <= 1'b0;
         s_pc_q  <= '0;     s_addr_q <= '0;    s_din_q   <= '0;
         s_we_q  <= 1'b0;   s_ven_q  <= 1'b0;  s_xg_q    <= '0;    s_yv_q <= '0;
         phase_q <= '0;     px_q     <= '0;    py_q      <= '0;
         instr_q <= '0;     rdata_q  <= '0;    vga_q     <= '0;
         daddr_q <= '0;     ddat_q   <= '0;    dwe_q     <= 1'b0;
         dburst_q <= 1'b0;  refresh_q <= 1'b0;
      end else begin
         state_q <= state_d;   issued_q <= issued_d;  pending_q <= pending_d;  clk_800k_q <= clk_800k;
         s_pc_q  <= s_pc_d;    s_addr_q <= s_addr_d;  s_din_q   <= s_din_d;
         s_we_q  <= s_we_d;    s_ven_q  <= s_ven_d;   s_xg_q    <= s_xg_d;    s_yv_q <= s_yv_d;
         phase_q <= phase_d;   px_q     <= px_d;      py_q      <= py_d;
         instr_q <= instr_d;   rdata_q  <= rdata_d;   vga_q     <= vga_d;
         daddr_q <= daddr_d;   ddat_q   <= ddat_d;    dwe_q     <= dwe_d;
         dburst_q <= dburst_d; refresh_q <= refresh_d;
      end
   end

   assign instr             = instr_q;
   assign read_data         = rdata_q;
   assign vga_bgr_buf       = vga_q;
   assign dram_addr         = daddr_q;
   assign dram_data_in      = ddat_q;
   assign dram_write_en     = dwe_q;
   assign dram_burst_en     = dburst_q;
   assign dram_refresh_data = refresh_q;

endmodule

// File: tb/tb_mem_mapper.sv
// Bench for mem_mapper: SDRAM controller responder plus a word-level memory-map reference model.
`timescale 1ns/1ps
module tb_mem_mapper;

   logic clk = 1'b0;
   logic rst, clk_800k, write_en, vga_en, uart_tx_ready;
   logic [15:0] pc, data_addr, data_in, instr, read_data, dram_data_in, dram_read_data;
   logic [4:0]  vga_x_group;
   logic [8:0]  vga_y_val;
   logic [31:0][11:0] vga_bgr_buf;
   logic [24:0] dram_addr;
   logic dram_write_en, dram_burst_en, dram_refresh_data, dram_data_ready, cpu_ready;
   logic [31:0][15:0] dram_burst_buf;

   always #5 clk = ~clk;

   mem_mapper dut (
      .clk(clk), .rst(rst), .clk_800k(clk_800k), .pc(pc), .data_addr(data_addr),
      .data_in(data_in), .write_en(write_en), .vga_en(vga_en), .vga_x_group(vga_x_group),
      .vga_y_val(vga_y_val), .uart_tx_ready(uart_tx_ready), .instr(instr), .read_data(read_data),
      .vga_bgr_buf(vga_bgr_buf), .dram_addr(dram_addr), .dram_data_in(dram_data_in),
      .dram_write_en(dram_write_en), .dram_burst_en(dram_burst_en),
      .dram_refresh_data(dram_refresh_data), .dram_read_data(dram_read_data),
      .dram_burst_buf(dram_burst_buf), .dram_data_ready(dram_data_ready), .cpu_ready(cpu_ready)
   );

   // Controller-side memory (what the DUT actually wrote) and reference-model memory.
   logic [15:0] dm [logic [24:0]];
   logic [15:0] mm [logic [24:0]];
   int refresh_cnt;
   int tests = 0;
   int fails = 0;

   function automatic logic [15:0] dread(input logic [24:0] a);
      return dm.exists(a) ? dm[a] : 16'h0;
   endfunction
   function automatic logic [15:0] mread(input logic [24:0] a);
      return mm.exists(a) ? mm[a] : 16'h0;
   endfunction

   initial begin : ctrl
      logic busy, cwe, cb;
      logic [24:0] ca;
      logic [15:0] cd;
      int cnt;
      busy = 1'b0; cwe = 1'b0; cb = 1'b0; ca = '0; cd = '0; cnt = 0;
      cpu_ready = 1'b0; dram_data_ready = 1'b0; dram_read_data = '0; dram_burst_buf = '0;
      refresh_cnt = 0;
      repeat (4) @(posedge clk);
      forever begin
         @(posedge clk); #1;
         dram_data_ready = 1'b0;
         if (!rst) begin
            busy = 1'b0; cpu_ready = 1'b0;
         end else if (busy) begin
            if (cnt > 0) cnt--;
            else begin
               if (cwe) dm[ca] = cd;
               else if (cb) for (int i = 0; i < 32; i++) dram_burst_buf[i] = dread(25'(ca + 25'(i)));
               else dram_read_data = dread(ca);
               dram_data_ready = 1'b1; busy = 1'b0; cpu_ready = 1'b1;
            end
         end else begin
            cpu_ready = 1'b1;
            if (dram_refresh_data) begin
               refresh_cnt++;
               ca = dram_addr; cwe = dram_write_en; cb = dram_burst_en; cd = dram_data_in;
               busy = 1'b1; cpu_ready = 1'b0; cnt = $urandom_range(0, 3);
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   // Reference model state
   int m_phase;
   logic [9:0] m_px;
   logic [8:0] m_py;
   logic [15:0] e_instr, e_rd;
   logic [31:0][11:0] e_vga;

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_cycle(input logic [15:0] p, input logic [15:0] a, input logic [15:0] d,
                            input logic w, input logic v, input logic [4:0] xg, input logic [8:0] yv);
      logic [24:0] wa, vb;
      logic [15:0] t;
      logic wr;
      wr = 1'b0; wa = '0;
      pc = p; data_addr = a; data_in = d; write_en = w; vga_en = v;
      vga_x_group = xg; vga_y_val = yv;
      e_instr = mread({9'b0, p});
      if (a < 16'hF800) begin
         if (w) begin wa = {9'b0, a}; mm[wa] = d; wr = 1'b1; end
         else e_rd = mread({9'b0, a});
      end else if (w) begin
         if (a == 16'hF80C) begin
            if (m_phase == 0) m_px = d[9:0];
            else if (m_phase == 1) m_py = d[8:0];
            else begin wa = {6'h1, m_py, m_px}; mm[wa] = {4'b0, d[11:0]}; wr = 1'b1; end
            m_phase = (m_phase + 1) % 3;
         end
      end else begin
`ifdef MEM_MAP_UART_STATUS_EN
         e_rd = (a == 16'hF808) ? {15'b0, uart_tx_ready} : 16'h0;
`else
         e_rd = 16'h0;
`endif
      end
      if (v) begin
         vb = {6'h1, yv, xg, 5'b0};
         for (int i = 0; i < 32; i++) begin
            t = mread(25'(vb + 25'(i)));
            e_vga[i] = t[11:0];
         end
      end
      clk_800k = 1'b1;
      repeat (32) @(posedge clk); #1;
      clk_800k = 1'b0;
      repeat (32) @(posedge clk); #1;
      chk("instr", instr, e_instr);
      chk("read_data", read_data, e_rd);
      if (v) chk("vga_bgr_buf", vga_bgr_buf, e_vga);
      if (wr) chk("dram_write", dread(wa), mread(wa));
   endtask

   initial begin : main
      logic [15:0] pre [6];
      logic [15:0] a, c;
      logic [31:0][11:0] vexp;
      int sel;
      pre = '{16'h0000, 16'h0009, 16'h0049, 16'h4809, 16'h47C9, 16'hE000};
      rst = 1'b0; clk_800k = 1'b0; pc = '0; data_addr = '0; data_in = '0; write_en = 1'b0;
      vga_en = 1'b0; vga_x_group = '0; vga_y_val = '0; uart_tx_ready = 1'b1;
      m_phase = 0; m_px = '0; m_py = '0; e_instr = '0; e_rd = '0; e_vga = '0;
      for (int i = 0; i < 6; i++) begin dm[25'(i)] = pre[i]; mm[25'(i)] = pre[i]; end
      repeat (3) @(posedge clk); #1;
      rst = 1'b1;
      repeat (20) @(posedge clk); #1;
      chk("reset_cpu_ready", cpu_ready, 1'b1);
      chk("reset_instr", instr, 16'h0);
      chk("reset_read_data", read_data, 16'h0);
      chk("reset_vga", vga_bgr_buf, '0);
      chk("reset_dram_we", dram_write_en, 1'b0);
      chk("no_refresh_before_edge", refresh_cnt, 0);

      cpu_cycle(16'd1, 16'd2, 16'h0, 1'b0, 1'b0, 5'd0, 9'd0);
      chk("tp_instr_0009", instr, 16'h0009);
      chk("tp_rd_0049", read_data, 16'h0049);
      cpu_cycle(16'd3, 16'd4, 16'h0, 1'b0, 1'b0, 5'd0, 9'd0);
      cpu_cycle(16'd3, 16'd4, 16'h0, 1'b0, 1'b0, 5'd0, 9'd0);
      chk("tp_rd_47c9_stable", read_data, 16'h47C9);
      cpu_cycle(16'd5, 16'd0, 16'hABAB, 1'b1, 1'b0, 5'd0, 9'd0);
      chk("tp_instr_e000", instr, 16'hE000);
      cpu_cycle(16'd0, 16'd5, 16'h0, 1'b0, 1'b0, 5'd0, 9'd0);
      chk("tp_write_then_fetch", instr, 16'hABAB);
      chk("tp_rd_e000", read_data, 16'hE000);

      for (int k = 0; k < 32; k++) begin
         c = {4'b0, 4'(k), 4'(k), 4'(k)};
         cpu_cycle(16'd1, 16'hF80C, 16'(32 + k), 1'b1, 1'b0, 5'd0, 9'd0);
         cpu_cycle(16'd2, 16'hF80C, 16'd7, 1'b1, 1'b0, 5'd0, 9'd0);
         cpu_cycle(16'd3, 16'hF80C, c, 1'b1, 1'b0, 5'd0, 9'd0);
      end
      chk("pix_32", dread({6'h1, 9'd7, 10'd32}), 16'h0000);
      chk("pix_33", dread({6'h1, 9'd7, 10'd33}), 16'h0111);
      chk("pix_34", dread({6'h1, 9'd7, 10'd34}), 16'h0222);

      cpu_cycle(16'd4, 16'd3, 16'h0, 1'b0, 1'b1, 5'd1, 9'd7);
      for (int i = 0; i < 32; i++) vexp[i] = {3{4'(i)}};
      chk("tp_vga_line", vga_bgr_buf, vexp);

      uart_tx_ready = 1'b1;
      cpu_cycle(16'd1, 16'hF808, 16'h0, 1'b0, 1'b0, 5'd0, 9'd0);
      cpu_cycle(16'd1, 16'hF80A, 16'h0, 1'b0, 1'b0, 5'd0, 9'd0);
      chk("tp_f80a_zero", read_data, 16'h0000);

      // Reset mid-sequence after one pixel-x write must return the pixel port to phase 0.
      cpu_cycle(16'd2, 16'hF80C, 16'd100, 1'b1, 1'b0, 5'd0, 9'd0);
      pc = 16'd3; data_addr = 16'd4; write_en = 1'b0; vga_en = 1'b1;
      clk_800k = 1'b1;
      repeat (3) @(posedge clk); #1;
      rst = 1'b0; clk_800k = 1'b0;
      repeat (2) @(posedge clk); #1;
      rst = 1'b1;
      m_phase = 0; e_instr = '0; e_rd = '0; e_vga = '0;
      repeat (10) @(posedge clk); #1;
      chk("abort_instr", instr, e_instr);
      chk("abort_read_data", read_data, e_rd);
      chk("abort_vga", vga_bgr_buf, e_vga);
      cpu_cycle(16'd1, 16'hF80C, 16'd200, 1'b1, 1'b0, 5'd0, 9'd0);
      cpu_cycle(16'd1, 16'hF80C, 16'd9, 1'b1, 1'b0, 5'd0, 9'd0);
      cpu_cycle(16'd1, 16'hF80C, 16'h0ABC, 1'b1, 1'b0, 5'd0, 9'd0);
      chk("abort_phase0_pixel", dread({6'h1, 9'd9, 10'd200}), 16'h0ABC);

      for (int k = 0; k < 30; k++) begin
         sel = $urandom_range(0, 5);
         if (sel < 3) a = 16'($urandom_range(0, 63));
         else if (sel == 3) a = 16'hF80C;
         else if (sel == 4) a = 16'hF808;
         else a = 16'(16'hF800 + $urandom_range(0, 15));
         uart_tx_ready = 1'($urandom_range(0, 1));
         cpu_cycle(16'($urandom_range(0, 63)), a, 16'($urandom), 1'($urandom_range(0, 1)),
                   (k % 4) == 0, 5'($urandom), 9'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
